serial_transmitter_fifo: RTL

//  Parametrised UART transmitter, successor to the fixed 8N1 transmitter.
//  - Configurable data width, parity mode and stop-bit count.
//  - Small TX FIFO so a host can queue bursts; frames then go out back-to-back.
//  - Sits between a byte/word producer (CPU bus bridge, debug streamer) and an FPGA TX pin.

---
 rtl/serial_transmitter_fifo.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/serial_transmitter_fifo.sv
// serial_transmitter_fifo
// UART transmitter with a configurable frame format (5..9 data bits, none/even/odd
// parity, 1 or 2 stop bits) and a small TX FIFO. Queued words are sent back-to-back
// without idle time between frames. The serial output and all status outputs are registered.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// stIdle   | line high, waiting for a queued word
// stStart  | start bit (low), head word already popped into shift_q
// stData   | data bits, LSB first, shift_q moves right after each bit
// stParity | single parity bit computed on the popped word
// stStop   | pStopBits high bit times; the next queued word is popped on the last tick
module serial_transmitter_fifo #(
    parameter int pClockFrequency = 24000000,
    parameter int pBaudRate       = 4000000,
    parameter int pDataBits       = 8,
    parameter int pParity         = 0,
    parameter int pStopBits       = 1,
    parameter int pFifoDepth      = 4
) (
    input  logic                          iClock,
    input  logic                          iReset,
    input  logic [pDataBits-1:0]          iData,
    input  logic                          iSend,
    output logic                          oReady,
    output logic                          oBusy,
    output logic [$clog2(pFifoDepth):0]   oFifoLevel,
    output logic                          oTxd
);

    localparam int TICKS  = pClockFrequency / pBaudRate;
    localparam int TICK_W = (TICKS > 2) ? $clog2(TICKS) : 2;
    localparam int PTR_W  = (pFifoDepth > 1) ? $clog2(pFifoDepth) : 1;
    localparam int LVL_W  = $clog2(pFifoDepth) + 1;
    localparam int BIT_W  = 4;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(pDataBits - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(pStopBits - 1);
    localparam logic [LVL_W-1:0]  DEPTH     = LVL_W'(pFifoDepth);

    // Elaboration-time rejection of unsupported configurations.
    if (TICKS < 3) begin : g_bad_ticks
        $fatal(1, "serial_transmitter_fifo: clock/baud ratio %0d is below 3", TICKS);
    end
    if (pDataBits < 5 || pDataBits > 9) begin : g_bad_data_bits
        $fatal(1, "serial_transmitter_fifo: pDataBits %0d outside 5..9", pDataBits);
    end
    if (pParity < 0 || pParity > 2) begin : g_bad_parity
        $fatal(1, "serial_transmitter_fifo: pParity %0d not in 0..2", pParity);
    end
    if (pStopBits != 1 && pStopBits != 2) begin : g_bad_stop_bits
        $fatal(1, "serial_transmitter_fifo: pStopBits %0d not 1 or 2", pStopBits);
    end
    if (pFifoDepth < 2 || (pFifoDepth & (pFifoDepth - 1)) != 0) begin : g_bad_depth
        $fatal(1, "serial_transmitter_fifo: pFifoDepth %0d not a power of 2 >= 2", pFifoDepth);
    end

    typedef enum logic [2:0] {
        stIdle   = 3'd0,
        stStart  = 3'd1,
        stData   = 3'd2,
        stParity = 3'd3,
        stStop   = 3'd4
    } state_t;

    state_t                 state_q,  state_d;
    logic [TICK_W-1:0]      tick_q,   tick_d;
    logic [BIT_W-1:0]       bit_q,    bit_d;
    logic [pDataBits-1:0]   shift_q,  shift_d;
    logic                   par_q,    par_d;
    logic                   txd_q,    txd_d;
    logic                   busy_q,   busy_d;
    logic                   ready_q,  ready_d;
    logic [PTR_W-1:0]       wr_q,     wr_d;
    logic [PTR_W-1:0]       rd_q,     rd_d;
    logic [LVL_W-1:0]       count_q,  count_d;
    logic [pDataBits-1:0]   mem_q [pFifoDepth];
    logic [pDataBits-1:0]   mem_d [pFifoDepth];

    logic                   push;
    logic                   pop;
    logic                   bit_end;

    // Next-state logic: bit timer, frame sequencing, FIFO bookkeeping and output decode.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        mem_d   = mem_q;
        pop     = 1'b0;

        // oReady is registered, so it already reflects "not full" for this edge.
        push    = iSend && ready_q;
        bit_end = (tick_q == TICK_LAST);

        if (state_q != stIdle) begin
            tick_d = bit_end ? '0 : tick_q + 1'b1;
        end

        case (state_q)
            stIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = stStart;
                    tick_d  = '0;
                end
            end
            stStart: begin
                if (bit_end) begin
                    state_d = stData;
                    bit_d   = '0;
                end
            end
            stData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (pParity != 0) ? stParity : stStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            stParity: begin
                if (bit_end) begin
                    state_d = stStop;
                    bit_d   = '0;
                end
            end
            stStop: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        // Chain straight into the next start bit when a word is waiting.
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            state_d = stStart;
                        end else begin
                            state_d = stIdle;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = stIdle;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase

        // Parity is fixed at pop time so shifting never disturbs it.
        if (pop) begin
            shift_d = mem_q[rd_q];
            par_d   = (pParity == 2) ? ~^mem_q[rd_q] : ^mem_q[rd_q];
            rd_d    = rd_q + 1'b1;
        end

        if (push) begin
            mem_d[wr_q] = iData;
            wr_d        = wr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Line level follows the state one clock later, keeping oTxd a plain flop output.
        case (state_q)
            stStart:  txd_d = 1'b0;
            stData:   txd_d = shift_q[0];
            stParity: txd_d = par_q;
            default:  txd_d = 1'b1;
        endcase

        busy_d  = (state_d != stIdle);
        ready_d = (count_d < DEPTH);
    end

    // Control and status registers with synchronous reset; reset aborts any frame and flushes the queue.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= stIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // FIFO storage; contents are don't-care after reset because the pointers are cleared.
    always_ff @(posedge iClock) begin
        mem_q <= mem_d;
    end

    assign oTxd       = txd_q;
    assign oBusy      = busy_q;
    assign oReady     = ready_q;
    assign oFifoLevel = count_q;

endmodule
